stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit registered stream multiplexer; next generation of the team's 4:1 combinational mux.
- Adds valid/ready handshakes on every input and on the output, plus a registered output stage.
- Two selection modes: fixed select (the classic mux behaviour) and round-robin arbitration across valid channels.
- Sits between multiple producer blocks and a single shared consumer; also provides a transfer counter for bench and debug visibility.

---
 rtl/stream_mux_rr_if.sv | 32 +++
 rtl/stream_mux_rr.sv | 126 ++++++++++++
 tb/tb_stream_mux_rr.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_if
// Brief    : Handshake bundle between N producers, the stream mux and one
//            shared consumer. Master = producers/consumer side, slave = mux.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N-channel registered stream multiplexer with valid/ready on every
//            port, fixed-select or round-robin arbitration and a wrapping
//            transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  stream_mux_rr_if.slave    bus,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Reset value of last_grant makes the first round-robin scan start at 0.
  localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(N_CH - 1);

  logic             can_load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic [N_CH-1:0]  in_ready_vec;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic [SEL_W-1:0] out_ch_q,     out_ch_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] xfer_cnt_q,   xfer_cnt_d;

  // Single output register: refill when empty or being drained this cycle.
  assign can_load = !out_valid_q | bus.out_ready;

  // Grant decision: fixed select, or round-robin scan after last_grant.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (!mode) begin
      // Out-of-range sel matches no channel and therefore never grants.
      for (int i = 0; i < N_CH; i++) begin
        if ((sel == SEL_W'(i)) && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end else begin
      // Scan offsets from farthest to nearest so the nearest valid channel
      // after last_grant is the one left standing.
      for (int k = N_CH; k >= 1; k--) begin
        for (int j = 0; j < N_CH; j++) begin
          if (bus.in_valid[j] &&
              (((int'(last_grant_q) + k) % N_CH) == j)) begin
            grant_valid = 1'b1;
            grant       = SEL_W'(j);
          end
        end
      end
    end
  end

  // Data path mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-channel ready: only the granted channel, only when the register can load.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready_vec[gi] = can_load & grant_valid & (grant == SEL_W'(gi));
  end

  assign bus.in_ready = in_ready_vec;

  // Next-state for the output stage, arbitration pointer and counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q;
    if (can_load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d   = grant_data;
        out_ch_d     = grant;
        last_grant_d = grant;
        xfer_cnt_d   = xfer_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= C_LAST_CH;
      xfer_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign xfer_cnt      = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Scoreboard bench for stream_mux_rr: a 4-channel/16-bit-counter
//            instance and a 5-channel/4-bit-counter instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

  logic clk;
  logic rst_n;

  logic        mode4, mode5;
  logic [1:0]  sel4;
  logic [2:0]  sel5;
  logic [15:0] xfer_cnt4;
  logic [3:0]  xfer_cnt5;

  logic [7:0]  d4 [4];
  logic [7:0]  d5 [5];

  // Expected words: {channel, data}
  logic [15:0] sb4 [$];
  logic [15:0] sb5 [$];

  int vectors;
  int miscompares;

  stream_mux_rr_if #(.WIDTH(8), .N_CH(4)) bus4 ();
  stream_mux_rr_if #(.WIDTH(8), .N_CH(5)) bus5 ();

  stream_mux_rr #(.WIDTH(8), .N_CH(4), .CNT_W(16)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode4),
    .sel      (sel4),
    .bus      (bus4.slave),
    .xfer_cnt (xfer_cnt4)
  );

  stream_mux_rr #(.WIDTH(8), .N_CH(5), .CNT_W(4)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode5),
    .sel      (sel5),
    .bus      (bus5.slave),
    .xfer_cnt (xfer_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for the 4-channel instance: every completed output handshake pops one word.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (sb4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon4 unexpected word: got ch=%0d data=0x%0h, expected none",
                 bus4.out_ch, bus4.out_data);
      end else begin
        logic [15:0] e;
        e = sb4.pop_front();
        check("mon4 out_ch",   32'(bus4.out_ch),   32'(e[15:8]));
        check("mon4 out_data", 32'(bus4.out_data), 32'(e[7:0]));
      end
    end
  end

  // Monitor for the 5-channel instance.
  always @(negedge clk) begin
    if (rst_n && bus5.out_valid && bus5.out_ready) begin
      if (sb5.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon5 unexpected word: got ch=%0d data=0x%0h, expected none",
                 bus5.out_ch, bus5.out_data);
      end else begin
        logic [15:0] e;
        e = sb5.pop_front();
        check("mon5 out_ch",   32'(bus5.out_ch),   32'(e[15:8]));
        check("mon5 out_data", 32'(bus5.out_data), 32'(e[7:0]));
      end
    end
  end

  // One cycle on the 4-channel instance: drive, check in_ready, queue accepted word.
  task automatic apply4(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] er, input string nm);
    mode4 = m;
    sel4  = s;
    bus4.in_valid  = v;
    bus4.out_ready = r;
    bus4.in_data   = {d4[3], d4[2], d4[1], d4[0]};
    #1;
    check({nm, " in_ready"}, 32'(bus4.in_ready), 32'(er));
    for (int i = 0; i < 4; i++) if (er[i]) sb4.push_back({8'(i), d4[i]});
    @(posedge clk);
    #1;
  endtask

  task automatic apply5(input logic m, input logic [2:0] s, input logic [4:0] v,
                        input logic r, input logic [4:0] er, input string nm);
    mode5 = m;
    sel5  = s;
    bus5.in_valid  = v;
    bus5.out_ready = r;
    bus5.in_data   = {d5[4], d5[3], d5[2], d5[1], d5[0]};
    #1;
    check({nm, " in_ready"}, 32'(bus5.in_ready), 32'(er));
    for (int i = 0; i < 5; i++) if (er[i]) sb5.push_back({8'(i), d5[i]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    mode4 = 1'b0; sel4 = '0; mode5 = 1'b0; sel5 = '0;
    for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) d5[i] = 8'h50 + 8'(i);
    bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
    bus5.in_data = '0; bus5.in_valid = '0; bus5.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst out_valid4", 32'(bus4.out_valid), 32'd0);
    check("rst out_data4",  32'(bus4.out_data),  32'd0);
    check("rst out_ch4",    32'(bus4.out_ch),    32'd0);
    check("rst xfer_cnt4",  32'(xfer_cnt4),      32'd0);
    check("rst out_valid5", 32'(bus5.out_valid), 32'd0);
    check("rst xfer_cnt5",  32'(xfer_cnt5),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: nothing valid, output stays empty
    apply4(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "idle0");
    apply4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "idle1");
    check("idle out_valid", 32'(bus4.out_valid), 32'd0);

    // Fixed select of channel 2
    d4[2] = 8'hA5;
    apply4(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, "fix sel2");
    check("fix sel2 out_valid", 32'(bus4.out_valid), 32'd1);
    apply4(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, "fix drain");
    check("fix drain out_valid", 32'(bus4.out_valid), 32'd0);
    check("fix xfer_cnt", 32'(xfer_cnt4), 32'd1);
    // Selected channel not valid: no grant even though others are valid
    apply4(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, "fix sel1 idle");
    check("fix sel1 out_valid", 32'(bus4.out_valid), 32'd0);

    // Accept a word, stall it, then reset asynchronously mid-stall
    d4[3] = 8'h3C;
    apply4(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, "fix sel3");
    apply4(1'b0, 2'd3, 4'b0000, 1'b0, 4'b0000, "pre-rst stall");
    check("pre-rst out_valid", 32'(bus4.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(bus4.out_valid), 32'd0);
    check("async rst out_data",  32'(bus4.out_data),  32'd0);
    check("async rst xfer_cnt",  32'(xfer_cnt4),      32'd0);
    sb4.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin fairness: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 8; k++)
      apply4(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)), "rr fair");
    apply4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "rr drain");
    check("rr xfer_cnt", 32'(xfer_cnt4), 32'd8);

    // Sparse round-robin, then wrap to channel 0
    apply4(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "sparse a");
    apply4(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, "sparse b");
    apply4(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "sparse c");
    apply4(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, "sparse d");
    apply4(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, "sparse wrap");

    // Backpressure: accept ch1, stall 3 cycles, release back-to-back
    apply4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "bp load");
    for (int k = 0; k < 3; k++) begin
      if (k == 1) apply4(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, "bp stall");
      else        apply4(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, "bp stall");
      check("bp out_valid", 32'(bus4.out_valid), 32'd1);
      check("bp out_data",  32'(bus4.out_data),  32'h11);
      check("bp out_ch",    32'(bus4.out_ch),    32'd1);
      check("bp xfer_cnt",  32'(xfer_cnt4),      32'd14);
    end
    apply4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "bp release");
    check("bp release out_ch", 32'(bus4.out_ch), 32'd2);
    apply4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp drain");
    check("bp final xfer_cnt", 32'(xfer_cnt4), 32'd15);
    check("bp final out_valid", 32'(bus4.out_valid), 32'd0);

    // 5-channel instance: out-of-range select never grants
    apply5(1'b0, 3'd5, 5'b11111, 1'b1, 5'b00000, "sel5 oor");
    check("sel5 out_valid", 32'(bus5.out_valid), 32'd0);
    apply5(1'b0, 3'd4, 5'b11111, 1'b1, 5'b10000, "sel4");
    // Round-robin wraps past 4 to 0; 17 transfers total on a 4-bit counter
    for (int k = 0; k < 16; k++)
      apply5(1'b1, 3'd0, 5'b11111, 1'b1, 5'(1 << (k % 5)), "rr5");
    apply5(1'b1, 3'd0, 5'b00000, 1'b1, 5'b00000, "rr5 drain");
    check("cnt wrap xfer_cnt5", 32'(xfer_cnt5), 32'd1);

    check("sb4 empty", 32'(sb4.size()), 32'd0);
    check("sb5 empty", 32'(sb5.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
